// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and one-hot grant constants.
// State encoding equals the grant encoding, so the grant output is the state register itself.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_P0   = 2'b01;
    localparam logic [1:0] GRANT_P1   = 2'b10;

endpackage

// File: rtl/dmem_arbiter_pick.sv
// Next-owner decision used when the arbiter leaves IDLE.
// DMEM_ARB_RR_EN selects round-robin tie-breaking; otherwise port 0 wins ties.
module dmem_arbiter_pick (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_owner,
    output logic o_pick1
);

`ifdef DMEM_ARB_RR_EN
    // Tie goes to the port that did not own last.
    assign o_pick1 = i_req1 & (~i_req0 | ~i_last_owner);
`else
    logic w_unused_last;
    assign w_unused_last = i_last_owner;
    assign o_pick1       = i_req1 & ~i_req0;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory (port 0 = CPU, port 1 = loader/DMA).
// Registered grant, combinational mux to memory, burst-bounded ownership; DMEM_ARB_RR_EN enables round-robin ties.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req0,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic              i_req1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack0,
    output logic [DATA_W-1:0] o_rdata0,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [1:0]        o_grant,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int              CNT_W    = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_owner;

    logic   w_pick1;
    logic   w_own_req;
    logic   w_oth_req;
    state_t w_other_st;

    dmem_arbiter_pick u_pick (
        .i_req0       (i_req0),
        .i_req1       (i_req1),
        .i_last_owner (r_last_owner),
        .o_pick1      (w_pick1)
    );

    assign w_own_req  = (r_state == ST_OWN0) ? i_req0 : (r_state == ST_OWN1) ? i_req1 : 1'b0;
    assign w_oth_req  = (r_state == ST_OWN0) ? i_req1 : (r_state == ST_OWN1) ? i_req0 : 1'b0;
    assign w_other_st = (r_state == ST_OWN0) ? ST_OWN1 : ST_OWN0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last_owner <= 1'b1;
        end else begin
            case (r_state)
                ST_OWN0, ST_OWN1: begin
                    if (w_own_req) begin
                        // Burst limit only yields when the other port is waiting.
                        if (r_cnt == CNT_LAST) begin
                            r_cnt <= '0;
                            if (w_oth_req) begin
                                r_state      <= w_other_st;
                                r_last_owner <= (w_other_st == ST_OWN1);
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                        if (w_oth_req) begin
                            r_state      <= w_other_st;
                            r_last_owner <= (w_other_st == ST_OWN1);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_cnt <= '0;
                    if (i_req0 | i_req1) begin
                        r_state      <= w_pick1 ? ST_OWN1 : ST_OWN0;
                        r_last_owner <= w_pick1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_grant = reset ? GRANT_NONE : r_state;

    // Outputs gated by reset so a write in flight is dropped before the edge.
    always_comb begin
        o_ack0      = 1'b0;
        o_ack1      = 1'b0;
        o_rdata0    = '0;
        o_rdata1    = '0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (!reset) begin
            if (r_state == ST_OWN0) begin
                o_ack0      = i_req0;
                o_mem_read  = i_req0 & ~i_we0;
                o_mem_write = i_req0 & i_we0;
                o_mem_addr  = i_addr0;
                o_mem_wdata = i_wdata0;
                o_rdata0    = (i_req0 & ~i_we0) ? i_mem_rdata : '0;
            end else if (r_state == ST_OWN1) begin
                o_ack1      = i_req1;
                o_mem_read  = i_req1 & ~i_we1;
                o_mem_write = i_req1 & i_we1;
                o_mem_addr  = i_addr1;
                o_mem_wdata = i_wdata1;
                o_rdata1    = (i_req1 & ~i_we1) ? i_mem_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_dmem_arbiter;

    localparam int BURST_MAX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b1;
    logic        b_req [2];
    logic        b_we [2];
    logic [31:0] b_addr [2];
    logic [31:0] b_wdata [2];

    logic        ack0, ack1, mem_read, mem_write;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant;

    logic [31:0] env_mem [64];
    logic [31:0] ref_mem [64];

    int m_own, m_beats, m_last;
    int n_o, n_b, n_l;
    logic last_ack [2];
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .reset(reset),
        .i_req0(b_req[0]), .i_we0(b_we[0]), .i_addr0(b_addr[0]), .i_wdata0(b_wdata[0]),
        .i_req1(b_req[1]), .i_we1(b_we[1]), .i_addr1(b_addr[1]), .i_wdata1(b_wdata[1]),
        .o_ack0(ack0), .o_rdata0(rdata0), .o_ack1(ack1), .o_rdata1(rdata1),
        .o_grant(grant), .o_mem_read(mem_read), .o_mem_write(mem_write),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // Data memory: combinational read, write at the edge.
    assign mem_rdata = env_mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= '0;
        end else if (mem_write) begin
            env_mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    function automatic int tie_winner(input int last);
`ifdef DMEM_ARB_RR_EN
        return 1 - last;
`else
        return (last >= 0) ? 0 : 0;
`endif
    endfunction

    // Owner bookkeeping: -1 = nobody; beats = acked beats in the current tenure modulo BURST_MAX.
    function automatic void mstep(input int own, input int beats, input int last,
                                  input logic r0, input logic r1,
                                  output int no, output int nb, output int nl);
        logic mine, other;
        no = own; nb = beats; nl = last;
        if (own < 0) begin
            if (r0 || r1) begin
                no = (r0 && r1) ? tie_winner(last) : (r0 ? 0 : 1);
                nb = 0;
                nl = no;
            end
        end else begin
            mine  = (own == 0) ? r0 : r1;
            other = (own == 0) ? r1 : r0;
            if (mine) begin
                nb = beats + 1;
                if (nb == BURST_MAX) begin
                    nb = 0;
                    if (other) begin no = 1 - own; nl = no; end
                end
            end else begin
                nb = 0;
                no = other ? 1 - own : -1;
                if (other) nl = no;
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_own   <= -1;
            m_beats <= 0;
            m_last  <= 1;
            if (clr) for (int i = 0; i < 64; i++) ref_mem[i] <= '0;
        end else begin
            mstep(m_own, m_beats, m_last, b_req[0], b_req[1], n_o, n_b, n_l);
            if (m_own >= 0 && b_req[m_own] && b_we[m_own])
                ref_mem[b_addr[m_own][7:2]] <= b_wdata[m_own];
            m_own   <= n_o;
            m_beats <= n_b;
            m_last  <= n_l;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp();
        logic ea [2];
        logic [31:0] er [2];
        logic emr, emw;
        for (int p = 0; p < 2; p++) begin
            ea[p] = (m_own == p) && b_req[p];
            er[p] = (ea[p] && !b_we[p]) ? ref_mem[b_addr[p][7:2]] : 32'h0;
        end
        emr = (m_own >= 0) && b_req[m_own] && !b_we[m_own];
        emw = (m_own >= 0) && b_req[m_own] && b_we[m_own];
        chk("grant", grant, (m_own < 0) ? 2'b00 : (m_own == 0) ? 2'b01 : 2'b10);
        chk("ack0", ack0, ea[0]);
        chk("ack1", ack1, ea[1]);
        chk("rdata0", rdata0, er[0]);
        chk("rdata1", rdata1, er[1]);
        chk("mem_read", mem_read, emr);
        chk("mem_write", mem_write, emw);
        if (emr || emw) chk("mem_addr", mem_addr, b_addr[m_own]);
        if (emw) chk("mem_wdata", mem_wdata, b_wdata[m_own]);
        last_ack = ea;
    endtask

    task automatic cyc(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        @(negedge clk);
        b_req[0] = r0; b_we[0] = w0; b_addr[0] = a0; b_wdata[0] = d0;
        b_req[1] = r1; b_we[1] = w1; b_addr[1] = a1; b_wdata[1] = d1;
        #1 cmp();
    endtask

    task automatic do_reset();
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            b_req[p] = 0; b_we[p] = 0; b_addr[p] = 0; b_wdata[p] = 0;
        end
        reset = 1;
        @(posedge clk);
        @(posedge clk);
        #1 cmp();
        chk("rst_grant", grant, 2'b00);
        @(negedge clk);
        reset = 0;
        clr = 0;
    endtask

    initial begin
        int cnt;
        logic ok;
        last_ack[0] = 0; last_ack[1] = 0;

        // 1: write then read back through port 0
        do_reset();
        cyc(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("t1_grant_n", grant, 2'b00);
        chk("t1_ack_n", ack0, 1'b0);
        cyc(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("t1_grant", grant, 2'b01);
        chk("t1_ack_w", ack0, 1'b1);
        chk("t1_memw", mem_write, 1'b1);
        cyc(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
        chk("t1_ack_r", ack0, 1'b1);
        chk("t1_rdata", rdata0, 32'hDEADBEEF);

        // 2: ties after reset and after one tenure
        do_reset();
        cyc(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        chk("t2_grant_n", grant, 2'b00);
        cyc(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        chk("t2_first", grant, 2'b01);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        chk("t2_idle", grant, 2'b00);
        cyc(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
`ifdef DMEM_ARB_RR_EN
        chk("t2_second", grant, 2'b10);
`else
        chk("t2_second", grant, 2'b01);
`endif

        // 3: burst limit hands over after 4 port-1 beats
        do_reset();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(i >= 2, 0, 32'h44, 0, 1, 0, 32'h40, 0);
            cnt += int'(ack1);
        end
        chk("t3_ack1_cnt", cnt, 4);
        chk("t3_grant", grant, 2'b01);

        // 4: owner drops while other raises -> direct handover
        do_reset();
        cyc(1, 0, 32'h8, 0, 0, 0, 0, 0);
        cyc(1, 0, 32'h8, 0, 0, 0, 0, 0);
        chk("t4_own0", grant, 2'b01);
        cyc(0, 0, 0, 0, 1, 0, 32'hC, 0);
        chk("t4_hold", grant, 2'b01);
        chk("t4_ack1_n", ack1, 1'b0);
        cyc(0, 0, 0, 0, 1, 0, 32'hC, 0);
        chk("t4_own1", grant, 2'b10);
        chk("t4_ack1", ack1, 1'b1);

        // 5: reset in the middle of a port-1 write
        do_reset();
        cyc(0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678);
        cyc(0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678);
        chk("t5_grant", grant, 2'b10);
        chk("t5_memw", mem_write, 1'b1);
        reset = 1;
        #1;
        chk("t5_rst_grant", grant, 2'b00);
        chk("t5_rst_memw", mem_write, 1'b0);
        chk("t5_rst_ack", ack1, 1'b0);
        @(posedge clk);
        #1 chk("t5_mem", env_mem[8], 32'h0);
        do_reset();

        // 6: lone requester keeps the bus past the burst limit
        cnt = 0;
        ok = 1;
        for (int i = 0; i < 9; i++) begin
            cyc(1, 0, 32'h48, 0, 0, 0, 0, 0);
            cnt += int'(ack0);
            if (i >= 1 && grant != 2'b01) ok = 0;
        end
        chk("t6_ack0_cnt", cnt, 8);
        chk("t6_grant_kept", ok, 1'b1);

        // Random traffic; requests stay stable until acked
        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!b_req[p] || last_ack[p]) begin
                    b_req[p]   = ($urandom_range(0, 2) != 0);
                    b_we[p]    = 1'($urandom_range(0, 1));
                    b_addr[p]  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                    b_wdata[p] = $urandom;
                end
            end
            #1 cmp();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
